multdiv_ctrl: RTL and testbench

- Sequencer between the execute stage and the shared multi-cycle multiply/divide unit.
- Accepts a mult/div request flagged by the op decoder, latches the operands and destination, and issues a single start pulse to the unit.
- Stalls the pipeline until the unit reports ready, then presents one writeback beat: the result to rd, or the exception code to $rstatus (r30).
- Guards against a hung unit with a cycle timeout and supports pipeline flush mid-operation.

---
 rtl/multdiv_pkg.sv | 22 ++
 rtl/multdiv_timeout_counter.sv | 30 +++
 rtl/multdiv_ctrl.sv | 125 ++++++++++++
 tb/tb_multdiv_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the execute-stage multiply/divide sequencer.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] EXC_MUL     = 32'd4;
  localparam logic [31:0] EXC_DIV     = 32'd5;
  localparam logic [4:0]  ALU_MUL     = 5'b00110;
  localparam logic [4:0]  ALU_DIV     = 5'b00111;

  // Exception code written to $rstatus for the given operation kind.
  function automatic logic [31:0] exc_code(input logic is_mult);
    return is_mult ? EXC_MUL : EXC_DIV;
  endfunction

endpackage

// File: rtl/multdiv_timeout_counter.sv
// Cycle counter that flags when the unit has been busy for MAX_CYCLES cycles.
module multdiv_timeout_counter #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_W-1:0] count_r;

  // Busy-cycle count; clear has priority over enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign terminal = (count_r == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer between the execute stage and the shared multi-cycle mult/div unit:
// issues one start pulse, stalls until ready or timeout, then emits one writeback beat.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_is_mult,
  input  logic [31:0] req_opA,
  input  logic [31:0] req_opB,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy
);

  state_e     state_r;
  logic       is_mult_r;
  logic [4:0] rd_r;
  logic       wb_en_r;
  logic       timeout_s;
  logic       stall_s;

  multdiv_timeout_counter #(
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear    (state_r != BUSY),
    .enable   (state_r == BUSY),
    .terminal (timeout_s)
  );

  // Main sequencer; md_ready is only honoured in BUSY so a stale ready cannot complete a new op.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      is_mult_r    <= 1'b0;
      rd_r         <= 5'd0;
      wb_en_r      <= 1'b0;
      md_opA       <= 32'd0;
      md_opB       <= 32'd0;
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
    end else begin
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid && !flush) begin
            md_opA       <= req_opA;
            md_opB       <= req_opB;
            rd_r         <= req_rd;
            is_mult_r    <= req_is_mult;
            md_ctrl_mult <= req_is_mult;
            md_ctrl_div  <= !req_is_mult;
            state_r      <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          state_r <= flush ? IDLE : BUSY;
        end
        BUSY: begin
          if (flush) begin
            state_r <= IDLE;
          end else if (md_ready) begin
            wb_rd   <= md_exception ? RSTATUS_REG : rd_r;
            wb_data <= md_exception ? exc_code(is_mult_r) : md_result;
            wb_en_r <= md_exception || (rd_r != 5'd0);
            state_r <= DONE;
          end else if (timeout_s) begin
            wb_rd   <= RSTATUS_REG;
            wb_data <= exc_code(is_mult_r);
            wb_en_r <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= BUSY;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Stall decode; in IDLE it follows the request so the instruction freezes the same cycle.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE:    stall_s = req_valid & reset;
      START:   stall_s = 1'b1;
      BUSY:    stall_s = 1'b1;
      DONE:    stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  assign stall    = stall_s;
  assign busy     = (state_r != IDLE);
  assign wb_valid = (state_r == DONE) && wb_en_r && !flush;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed scenarios plus randomized ops
// against a cycle-level reference of the request/start/busy/writeback sequence.
module tb_multdiv_ctrl;

  localparam int MAXC = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_is_mult, flush;
  logic [31:0] req_opA, req_opB;
  logic [4:0]  req_rd;
  logic [31:0] md_opA, md_opB, md_result, wb_data;
  logic        md_ctrl_mult, md_ctrl_div, md_exception, md_ready;
  logic        stall, wb_valid, busy;
  logic [4:0]  wb_rd;

  int n_checks = 0;
  int n_pass   = 0;

  multdiv_ctrl #(.MAX_CYCLES(MAXC), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_is_mult(req_is_mult),
    .req_opA(req_opA), .req_opB(req_opB), .req_rd(req_rd), .flush(flush),
    .md_opA(md_opA), .md_opB(md_opB),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // d: BUSY cycle (1-based) on which the unit raises ready; 0 or >MAXC means never.
  // f: BUSY cycle on which flush is raised (0 = none); flush_done: flush in the DONE cycle.
  task automatic run_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int d, input logic [31:0] res,
                        input bit exc, input int f, input bit flush_done,
                        output int stall_cnt);
    int          busy_len;
    bit          timed_out, flushed;
    logic        exp_valid;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    timed_out = !(d >= 1 && d <= MAXC);
    busy_len  = timed_out ? MAXC : d;
    if (f >= 1 && f < busy_len) busy_len = f;
    stall_cnt = 0;
    flushed   = 1'b0;

    @(posedge clock); #1;
    req_valid = 1'b1; req_is_mult = is_mult; req_opA = a; req_opB = b; req_rd = rd;
    md_ready = 1'($urandom_range(0, 1)); flush = 1'b0;
    #1;
    n_checks++;
    if ({stall, busy, wb_valid} !== 3'b100)
      $display("FAIL req_cycle: stall/busy/wb_valid=%b expected 100", {stall, busy, wb_valid});
    else n_pass++;
    stall_cnt += int'(stall);

    @(posedge clock); #1;
    req_valid = 1'b0; req_is_mult = 1'($urandom_range(0, 1));
    req_opA = $urandom; req_opB = $urandom; req_rd = 5'($urandom);
    md_ready = 1'($urandom_range(0, 1));
    #1;
    n_checks++;
    if ({stall, busy, md_ctrl_mult, md_ctrl_div, md_opA, md_opB} !==
        {1'b1, 1'b1, is_mult, !is_mult, a, b})
      $display("FAIL start_cycle: stall=%b busy=%b mult=%b div=%b opA=%h opB=%h expected mult=%b opA=%h opB=%h",
               stall, busy, md_ctrl_mult, md_ctrl_div, md_opA, md_opB, is_mult, a, b);
    else n_pass++;
    stall_cnt += int'(stall);

    for (int k = 1; k <= busy_len; k++) begin
      @(posedge clock); #1;
      md_ready     = (k == d);
      md_result    = (k == d) ? res : $urandom;
      md_exception = (k == d) ? exc : 1'($urandom_range(0, 1));
      flush        = (k == f);
      #1;
      n_checks++;
      if ({stall, busy, md_ctrl_mult, md_ctrl_div, wb_valid, md_opA, md_opB} !==
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, b})
        $display("FAIL busy_cycle%0d: stall=%b busy=%b mult=%b div=%b wb_valid=%b opA=%h opB=%h",
                 k, stall, busy, md_ctrl_mult, md_ctrl_div, wb_valid, md_opA, md_opB);
      else n_pass++;
      stall_cnt += int'(stall);
      if (k == f) flushed = 1'b1;
    end

    @(posedge clock); #1;
    md_ready = 1'b0; flush = 1'b0;
    if (!flushed) begin
      if (timed_out || exc) begin
        exp_valid = 1'b1; exp_rd = 5'd30; exp_data = is_mult ? 32'd4 : 32'd5;
      end else begin
        exp_valid = (rd != 5'd0); exp_rd = rd; exp_data = res;
      end
      if (flush_done) exp_valid = 1'b0;
      flush = flush_done; md_ready = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if ({stall, wb_valid} !== {1'b0, exp_valid})
        $display("FAIL done_beat: stall=%b wb_valid=%b expected stall=0 wb_valid=%b",
                 stall, wb_valid, exp_valid);
      else n_pass++;
      if (exp_valid) begin
        n_checks++;
        if ({wb_rd, wb_data} !== {exp_rd, exp_data})
          $display("FAIL wb_payload: wb_rd=%0d wb_data=%h expected wb_rd=%0d wb_data=%h",
                   wb_rd, wb_data, exp_rd, exp_data);
        else n_pass++;
      end
      @(posedge clock); #1;
      flush = 1'b0; md_ready = 1'b0;
    end else begin
      md_ready = 1'b1;
      md_exception = 1'b0;
    end
    #1;
    n_checks++;
    if ({stall, busy, wb_valid, md_ctrl_mult, md_ctrl_div} !== 5'b00000)
      $display("FAIL back_to_idle: stall=%b busy=%b wb_valid=%b mult=%b div=%b expected all 0",
               stall, busy, wb_valid, md_ctrl_mult, md_ctrl_div);
    else n_pass++;
    md_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b1; req_is_mult = 1'b1; req_opA = 32'hFFFF_FFFF;
    req_opB = 32'hFFFF_FFFF; req_rd = 5'd31; flush = 1'b0;
    md_result = 32'd0; md_exception = 1'b0; md_ready = 1'b0;
    #12;
    n_checks++;
    if ({md_opA, md_opB, wb_data, wb_rd, stall, wb_valid, md_ctrl_mult, md_ctrl_div, busy} !== '0)
      $display("FAIL reset_state: opA=%h opB=%h wb_data=%h wb_rd=%0d stall=%b wb_valid=%b busy=%b",
               md_opA, md_opB, wb_data, wb_rd, stall, wb_valid, busy);
    else n_pass++;
    req_valid = 1'b0;
    @(posedge clock); #3;
    reset = 1'b1;
  endtask

  task automatic test_mul_basic();
    int sc;
    run_op(1'b1, 32'd6, 32'd7, 5'd5, 16, 32'd42, 1'b0, 0, 1'b0, sc);
    n_checks++;
    if (sc !== 18) $display("FAIL mul_stall_len: stall cycles=%0d expected 18", sc);
    else n_pass++;
  endtask

  task automatic test_div_by_zero();
    int sc;
    run_op(1'b0, 32'd10, 32'd0, 5'd9, 5, 32'hDEAD_BEEF, 1'b1, 0, 1'b0, sc);
  endtask

  task automatic test_mul_rd0();
    int sc;
    run_op(1'b1, 32'd3, 32'd4, 5'd0, 4, 32'd12, 1'b0, 0, 1'b0, sc);
  endtask

  task automatic test_timeout();
    int sc;
    run_op(1'b1, 32'd100, 32'd200, 5'd12, 0, 32'd0, 1'b0, 0, 1'b0, sc);
    n_checks++;
    if (sc !== MAXC + 2) $display("FAIL timeout_len: stall cycles=%0d expected %0d", sc, MAXC + 2);
    else n_pass++;
    run_op(1'b0, 32'd9, 32'd3, 5'd7, MAXC, 32'd3, 1'b0, 0, 1'b0, sc);
  endtask

  task automatic test_flush();
    int sc;
    run_op(1'b1, 32'd11, 32'd13, 5'd4, 5, 32'd143, 1'b0, 3, 1'b0, sc);
    run_op(1'b0, 32'd50, 32'd5, 5'd6, 2, 32'd10, 1'b0, 0, 1'b0, sc);
    run_op(1'b1, 32'd2, 32'd2, 5'd8, 3, 32'd4, 1'b0, 0, 1'b1, sc);
  endtask

  task automatic test_back_to_back();
    int sc, d, f;
    for (int i = 0; i < 20; i++) begin
      d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(41, 45)) : int'($urandom_range(1, 20));
      f = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 6)) : 0;
      run_op(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom), d, $urandom,
             1'($urandom_range(0, 1)), f, ($urandom_range(0, 4) == 0), sc);
    end
  endtask

  task automatic test_reset_mid_op();
    @(posedge clock); #1;
    req_valid = 1'b1; req_is_mult = 1'b0; req_opA = 32'h1234_5678; req_opB = 32'h9; req_rd = 5'd3;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #3;
    reset = 1'b0; req_valid = 1'b1;
    #1;
    n_checks++;
    if ({md_opA, md_opB, wb_data, wb_rd, stall, wb_valid, md_ctrl_mult, md_ctrl_div, busy} !== '0)
      $display("FAIL reset_mid_op: opA=%h opB=%h stall=%b wb_valid=%b busy=%b expected all 0",
               md_opA, md_opB, stall, wb_valid, busy);
    else n_pass++;
    req_valid = 1'b0;
    @(posedge clock); #3;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      md_ready = 1'b1;
      #1;
      n_checks++;
      if ({stall, busy, wb_valid, md_ctrl_mult, md_ctrl_div} !== 5'b00000)
        $display("FAIL post_reset_idle%0d: stall=%b busy=%b wb_valid=%b expected 0", i, stall, busy, wb_valid);
      else n_pass++;
    end
    md_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_div_by_zero();
    test_mul_rd0();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
